// File: rtl/pixel_plot_merger.sv
// Merges two pixel-plot streams into one VGA write port. Each channel collapses
// repeated strobes, buffers pixels in a small FIFO, and an alternating arbiter drains them.

module pixel_plot_channel #(
    parameter int DEPTH = 4,
    parameter int COLW  = 9
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [7:0]         x,
    input  logic [6:0]         y,
    input  logic [COLW-1:0]    colour,
    input  logic               plot,
    input  logic               pop,
    output logic [15+COLW-1:0] head,
    output logic               empty,
    output logic               overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 15 + COLW;

    logic [PW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [PW-1:0] pixel;
    logic [PW-1:0] last;
    logic          plot_d;
    logic          push;
    logic          full;
    logic          store;

    assign pixel = {x, y, colour};
    // A held strobe only counts again once the pixel itself changes.
    assign push  = plot && (!plot_d || (pixel != last));
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign store = push && (!full || pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            plot_d   <= 1'b0;
            last     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            plot_d <= plot;
            if (push)
                last <= pixel;
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !store)
                overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (store)
            mem[wr_ptr[AW-1:0]] <= pixel;
    end
endmodule

module pixel_plot_merger #(
    parameter int DEPTH = 4,
    parameter int COLW  = 9
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [7:0]      aX,
    input  logic [6:0]      aY,
    input  logic [COLW-1:0] aColour,
    input  logic            aPlot,
    input  logic [7:0]      bX,
    input  logic [6:0]      bY,
    input  logic [COLW-1:0] bColour,
    input  logic            bPlot,
    output logic [7:0]      oX,
    output logic [6:0]      oY,
    output logic [COLW-1:0] oColour,
    output logic            oPlot,
    output logic            aOverflow,
    output logic            bOverflow,
    output logic            idle
);
    localparam int PW = 15 + COLW;

    typedef enum logic {PRI_A, PRI_B} pri_t;

    pri_t          pri;
    logic [PW-1:0] a_head;
    logic [PW-1:0] b_head;
    logic          a_empty;
    logic          b_empty;
    logic          a_pop;
    logic          b_pop;

    pixel_plot_channel #(.DEPTH(DEPTH), .COLW(COLW)) u_chan_a (
        .clock    (clock),
        .resetn   (resetn),
        .x        (aX),
        .y        (aY),
        .colour   (aColour),
        .plot     (aPlot),
        .pop      (a_pop),
        .head     (a_head),
        .empty    (a_empty),
        .overflow (aOverflow)
    );

    pixel_plot_channel #(.DEPTH(DEPTH), .COLW(COLW)) u_chan_b (
        .clock    (clock),
        .resetn   (resetn),
        .x        (bX),
        .y        (bY),
        .colour   (bColour),
        .plot     (bPlot),
        .pop      (b_pop),
        .head     (b_head),
        .empty    (b_empty),
        .overflow (bOverflow)
    );

    // A wins when it is preferred, or when B has nothing to offer.
    assign a_pop = !a_empty && ((pri == PRI_A) || b_empty);
    assign b_pop = !b_empty && !a_pop;
    assign idle  = a_empty && b_empty && !oPlot;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pri     <= PRI_A;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
        end else begin
            oPlot <= a_pop || b_pop;
            if (a_pop) begin
                {oX, oY, oColour} <= a_head;
                pri               <= PRI_B;
            end else if (b_pop) begin
                {oX, oY, oColour} <= b_head;
                pri               <= PRI_A;
            end
        end
    end
endmodule

// File: tb/tb_pixel_plot_merger.sv
// Scoreboard bench for pixel_plot_merger: expected pixels (and the cycle they must
// appear) are queued as stimulus is driven and checked whenever oPlot is high.

module tb_pixel_plot_merger;
    localparam int COLW = 9;

    logic            clock   = 1'b0;
    logic            resetn  = 1'b1;
    logic [7:0]      aX      = '0;
    logic [6:0]      aY      = '0;
    logic [COLW-1:0] aColour = '0;
    logic            aPlot   = 1'b0;
    logic [7:0]      bX      = '0;
    logic [6:0]      bY      = '0;
    logic [COLW-1:0] bColour = '0;
    logic            bPlot   = 1'b0;
    logic [7:0]      oX;
    logic [6:0]      oY;
    logic [COLW-1:0] oColour;
    logic            oPlot;
    logic            aOverflow;
    logic            bOverflow;
    logic            idle;

    pixel_plot_merger #(.DEPTH(4), .COLW(COLW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .aX        (aX),
        .aY        (aY),
        .aColour   (aColour),
        .aPlot     (aPlot),
        .bX        (bX),
        .bY        (bY),
        .bColour   (bColour),
        .bPlot     (bPlot),
        .oX        (oX),
        .oY        (oY),
        .oColour   (oColour),
        .oPlot     (oPlot),
        .aOverflow (aOverflow),
        .bOverflow (bOverflow),
        .idle      (idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]      x;
        logic [6:0]      y;
        logic [COLW-1:0] c;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Every write pulse must match the head of the scoreboard, including its cycle.
    always @(negedge clock) begin
        if (resetn && oPlot) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot: got (%0d,%0d,%0h) at cycle %0d, expected no write",
                         oX, oY, oColour, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (oX !== mon_e.x || oY !== mon_e.y || oColour !== mon_e.c || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL out_pixel: got (%0d,%0d,%0h) at cycle %0d, expected (%0d,%0d,%0h) at cycle %0d",
                             oX, oY, oColour, cyc, mon_e.x, mon_e.y, mon_e.c, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input bit en, input int x, input int y, input int c);
        aPlot   = en;
        aX      = 8'(x);
        aY      = 7'(y);
        aColour = COLW'(c);
    endtask

    task automatic set_b(input bit en, input int x, input int y, input int c);
        bPlot   = en;
        bX      = 8'(x);
        bY      = 7'(y);
        bColour = COLW'(c);
    endtask

    task automatic push_exp(input int x, input int y, input int c, input int at);
        exp_t e;
        e.x   = 8'(x);
        e.y   = 7'(y);
        e.c   = COLW'(c);
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        aPlot  = 1'b0;
        bPlot  = 1'b0;
        resetn = 1'b0;
        step();
        sb.delete();
        resetn = 1'b1;
    endtask

    // Waits (bounded) for the scoreboard to empty, then a few more cycles so stray pulses surface.
    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        step();
    endtask

    task automatic test_reset();
        int pulses = 0;
        resetn = 1'b0;
        repeat (2) step();
        checks++;
        if (oPlot !== 1'b0 || {oX, oY, oColour} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got plot=%b pixel=(%0d,%0d,%0h), expected all 0", oPlot, oX, oY, oColour);
        end
        checks++;
        if (aOverflow !== 1'b0 || bOverflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got a=%b b=%b, expected 0 0", aOverflow, bOverflow);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %b, expected 1", idle);
        end
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (oPlot !== 1'b0) pulses++;
        end
        step();
        checks++;
        if (pulses != 0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_quiet: got %0d pulses idle=%b, expected 0 pulses idle=1", pulses, idle);
        end
    endtask

    task automatic test_dedup();
        int c0;
        do_reset();
        c0 = cyc;
        set_a(1, 10, 20, 'h1FF);
        push_exp(10, 20, 'h1FF, c0 + 2);
        step();
        step();
        aPlot = 1'b0;
        wait_drain(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL dedup_first: got %0d pending, expected 0", sb.size());
            sb.delete();
        end

        c0 = cyc;
        step();
        set_a(1, 10, 20, 'h1FF);
        push_exp(10, 20, 'h1FF, c0 + 3);
        step();
        aPlot = 1'b0;
        wait_drain(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL dedup_restrobe: got %0d pending, expected 0", sb.size());
            sb.delete();
        end

        // Strobe held high while the colour changes: two writes, then nothing for the hold.
        c0 = cyc;
        set_a(1, 10, 20, 'h1FF);
        push_exp(10, 20, 'h1FF, c0 + 2);
        step();
        set_a(1, 10, 20, 'h0AA);
        push_exp(10, 20, 'h0AA, c0 + 3);
        step();
        step();
        aPlot = 1'b0;
        wait_drain(10);
        checks++;
        if (sb.size() != 0 || aOverflow !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL dedup_change: got pending=%0d ovf=%b idle=%b, expected 0 0 1", sb.size(), aOverflow, idle);
            sb.delete();
        end
    endtask

    task automatic test_alternation();
        int c0;
        do_reset();
        c0 = cyc;
        for (int i = 1; i <= 3; i++) begin
            push_exp(i, 0, i, c0 + 2 * i);
            push_exp(i, 1, i + 3, c0 + 2 * i + 1);
        end
        for (int i = 1; i <= 3; i++) begin
            set_a(1, i, 0, i);
            set_b(1, i, 1, i + 3);
            step();
        end
        aPlot = 1'b0;
        bPlot = 1'b0;
        wait_drain(20);
        checks++;
        if (sb.size() != 0 || aOverflow !== 1'b0 || bOverflow !== 1'b0) begin
            errors++;
            $display("FAIL alternation: got pending=%0d aovf=%b bovf=%b, expected 0 0 0", sb.size(), aOverflow, bOverflow);
            sb.delete();
        end
    endtask

    task automatic test_overflow();
        int c0;
        int ai;
        // Output order with A backlogged: positive = A index, negative = B index (B8, B10 dropped).
        int seq [15] = '{1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 7, -7, -9};

        do_reset();
        c0 = cyc;
        for (int i = 1; i <= 6; i++) push_exp(i, 2, 'h40 + i, c0 + i + 1);
        for (int i = 1; i <= 6; i++) begin
            set_b(1, i, 2, 'h40 + i);
            step();
        end
        bPlot = 1'b0;
        wait_drain(20);
        checks++;
        if (sb.size() != 0 || bOverflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_solo: got pending=%0d bovf=%b, expected 0 0", sb.size(), bOverflow);
            sb.delete();
        end

        c0 = cyc;
        for (int k = 0; k < 15; k++) begin
            if (seq[k] > 0) push_exp(seq[k], 4, 'h20 + seq[k], c0 + k + 2);
            else            push_exp(-seq[k], 3, 'h80 - seq[k], c0 + k + 2);
        end
        ai = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k <= 3 || (k % 2) == 1) begin
                ai++;
                set_a(1, ai, 4, 'h20 + ai);
            end else begin
                aPlot = 1'b0;
            end
            if (k <= 10) set_b(1, k, 3, 'h80 + k);
            else         bPlot = 1'b0;
            step();
        end
        aPlot = 1'b0;
        bPlot = 1'b0;
        wait_drain(30);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL overflow_stream: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        checks++;
        if (bOverflow !== 1'b1 || aOverflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_flags: got a=%b b=%b, expected a=0 b=1", aOverflow, bOverflow);
        end
        repeat (10) step();
        checks++;
        if (bOverflow !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got bovf=%b idle=%b, expected 1 1", bOverflow, idle);
        end
    endtask

    task automatic test_full_pop();
        int c0;
        int seq [15] = '{1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 7, -7, 8};
        do_reset();
        c0 = cyc;
        for (int k = 0; k < 15; k++) begin
            if (seq[k] > 0) push_exp(seq[k], 5, 'h10 + seq[k], c0 + k + 2);
            else            push_exp(-seq[k], 6, 'h30 - seq[k], c0 + k + 2);
        end
        // A reaches DEPTH after edge 7; its edge-8 push coincides with a pop.
        for (int k = 1; k <= 8; k++) begin
            set_a(1, k, 5, 'h10 + k);
            if (k <= 7) set_b(1, k, 6, 'h30 + k);
            else        bPlot = 1'b0;
            step();
        end
        aPlot = 1'b0;
        wait_drain(30);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL full_pop_stream: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        checks++;
        if (aOverflow !== 1'b0 || bOverflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_flags: got a=%b b=%b, expected 0 0", aOverflow, bOverflow);
        end
    endtask

    task automatic test_reset_midstream();
        int c0;
        int pulses = 0;
        do_reset();
        c0 = cyc;
        push_exp(1, 7, 'h51, c0 + 2);
        push_exp(1, 8, 'h61, c0 + 3);
        push_exp(2, 7, 'h52, c0 + 4);
        for (int i = 1; i <= 5; i++) begin
            set_a(1, i, 7, 'h50 + i);
            set_b(1, i, 8, 'h60 + i);
            step();
        end
        aPlot = 1'b0;
        bPlot = 1'b0;
        checks++;
        if (oPlot !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL midstream_busy: got plot=%b idle=%b, expected 1 0", oPlot, idle);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (oPlot !== 1'b0 || idle !== 1'b1 || {oX, oY, oColour} !== '0) begin
            errors++;
            $display("FAIL midstream_reset: got plot=%b idle=%b pixel=(%0d,%0d,%0h), expected 0 1 (0,0,0)",
                     oPlot, idle, oX, oY, oColour);
        end
        #1 resetn = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midstream_prior: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (oPlot !== 1'b0) pulses++;
        end
        step();
        checks++;
        if (pulses != 0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL midstream_stale: got %0d pulses idle=%b, expected 0 pulses idle=1", pulses, idle);
        end
    endtask

    initial begin
        test_reset();
        test_dedup();
        test_alternation();
        test_overflow();
        test_full_pop();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
